pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Instruction-fetch stage upstream of the multi-cycle controller. Owns the PC,
//   fetches from instruction memory over a req/ready handshake and holds the word
//   in an instruction register. Supplies op to the controller.
//   Computes the next PC when the controller strobes next_pc, from jmp, branch and the ALU zero flag.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded on reset
//   MAX_WAIT  15             wait cycles tolerated per fetch before fetch_err is set (1..255)
// PORTS
//   clk          in   1   clock; all state changes on the rising edge
//   rst          in   1   asynchronous, active-high reset
//   next_pc      in   1   controller strobe: instruction finished, advance the PC
//   jmp          in   1   current instruction is J
//   branch       in   1   current instruction is BEQ
//   zero         in   1   ALU zero flag for the branch compare
//   imem_req     out  1   fetch request to instruction memory
//   imem_addr    out  32  fetch byte address (= pc)
//   imem_ready   in   1   memory accepts the request; imem_rdata is valid this cycle
//   imem_rdata   in   32  fetched instruction word
//   instr        out  32  instruction register
//   op           out  6   instr[31:26], to the controller
//   instr_valid  out  1   instr holds the instruction currently executing
//   pc           out  32  current PC
//   fetch_err    out  1   sticky: a fetch exceeded MAX_WAIT wait cycles
// BEHAVIOUR
//   Reset (async, any state): pc=RESET_PC, instr=0, instr_valid=0, imem_req=0,
//     fetch_err=0, wait counter=0, state=S_IDLE.
//   States: S_IDLE -> S_REQ -> (S_WAIT)* -> S_HOLD -> S_REQ ...
//   - S_IDLE: lasts exactly 1 cycle after reset deassertion, then S_REQ.
//   - S_REQ: imem_req=1, imem_addr=pc. If imem_ready=1, latch instr<=imem_rdata and go
//     to S_HOLD. Otherwise go to S_WAIT with wait counter=1.
//   - S_WAIT: imem_req stays 1 and imem_addr stays stable. If imem_ready=1, latch and go to
//     S_HOLD. Otherwise increment the counter, saturating at 255. When the counter reaches
//     MAX_WAIT, set fetch_err=1 (sticky until reset) and keep waiting; no abort.
//   - S_HOLD: imem_req=0, instr_valid=1, instr frozen. If next_pc=1 at a rising edge,
//     update pc, clear instr_valid and go to S_REQ.
//   Fetch latency: imem_ready in S_REQ gives instr_valid on the next cycle (1 cycle min).
//   PC update (registered, only in S_HOLD with next_pc=1); p4 = pc+32'd4, modulo 2^32:
//   - jmp=1: pc <= {p4[31:28], instr[25:0], 2'b00}. jmp takes priority over branch.
//   - branch=1 and zero=1: pc <= p4 + {{14{instr[15]}}, instr[15:0], 2'b00}, modulo 2^32.
//   - otherwise: pc <= p4. 32'hFFFF_FFFC wraps to 0.
//   Boundary conditions:
//   - next_pc outside S_HOLD is ignored; pc is unchanged.
//   - imem_ready outside S_REQ/S_WAIT is ignored.
//   - op = instr[31:26] at all times, including 0 after reset.
//   - reset in S_WAIT drops imem_req asynchronously; no stale word is latched afterwards.
// CONFIGURATION
//   FETCH_PERF_EN defined: adds outputs perf_fetches[31:0] and perf_waits[31:0], both 0
//     on reset. perf_fetches increments on each instr latch. perf_waits increments on each
//     S_WAIT cycle. Both wrap at 2^32.
//   FETCH_PERF_EN undefined: neither port nor the counters exist; all other behaviour is
//     identical.
// TESTING
//   1 Reset, then imem_ready tied 1 -> imem_req at addr 0 in cycle 2; instr_valid=1 in cycle 3.
//   2 Sequential: next_pc pulse at pc=0x10 with jmp=branch=0 -> pc=0x14; new req to 0x14.
//   3 BEQ at pc=0x20, imm=16'hFFFE, zero=1 -> pc=0x1C; same with zero=0 -> pc=0x24.
//   4 J at pc=0x4000_0000, target 26'h0000100 -> pc=0x4000_0400; branch=1 also set -> still 0x4000_0400.
//   5 imem_ready held 0 for 20 cycles, MAX_WAIT=15 -> fetch_err=1 after wait 15, addr stable;
//     ready then latches; fetch_err stays 1.
//   6 rst asserted mid S_WAIT -> imem_req=0 immediately, pc=RESET_PC; with FETCH_PERF_EN,
//     counters read 0.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-memory req/ready fetch bus
interface pc_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC, instruction fetch and instruction register
// FETCH_PERF_EN adds perf_fetches_o / perf_waits_o event counters.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               next_pc_i,
  input  logic               jmp_i,
  input  logic               branch_i,
  input  logic               zero_i,
  pc_fetch_unit_if.master    imem,
  output logic [31:0]        instr_o,
  output logic [5:0]         op_o,
  output logic               instr_valid_o,
  output logic [31:0]        pc_o,
  output logic               fetch_err_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetches_o,
  output logic [31:0]        perf_waits_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic [31:0] p4;
  logic [31:0] br_off;
  logic        fetching;
  logic        latch;

  assign p4       = pc_q + 32'd4;
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign fetching = (state_q == S_REQ) || (state_q == S_WAIT);
  assign latch    = fetching && imem.ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        wait_d  = 8'd0;
      end
      S_REQ, S_WAIT: begin
        if (imem.ready) begin
          instr_d = imem.rdata;
          state_d = S_HOLD;
          wait_d  = 8'd0;
        end else begin
          state_d = S_WAIT;
          if (state_q == S_REQ)
            wait_d = 8'd1;
          else if (wait_q != 8'hFF)
            wait_d = wait_q + 8'd1;
          // The error is sticky; the fetch keeps waiting for the memory.
          if (wait_d >= MAX_WAIT_C)
            err_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (next_pc_i) begin
          state_d = S_REQ;
          if (jmp_i)
            pc_d = {p4[31:28], instr_q[25:0], 2'b00};
          else if (branch_i && zero_i)
            pc_d = p4 + br_off;
          else
            pc_d = p4;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request is decoded from state so an async reset drops it immediately.
  assign imem.req      = fetching;
  assign imem.addr     = pc_q;
  assign instr_o       = instr_q;
  assign op_o          = instr_q[31:26];
  assign instr_valid_o = (state_q == S_HOLD);
  assign pc_o          = pc_q;
  assign fetch_err_o   = err_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetches_q;
  logic [31:0] perf_waits_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_fetches_q <= 32'd0;
      perf_waits_q   <= 32'd0;
    end else begin
      if (latch)
        perf_fetches_q <= perf_fetches_q + 32'd1;
      if (state_q == S_WAIT)
        perf_waits_q <= perf_waits_q + 32'd1;
    end
  end

  assign perf_fetches_o = perf_fetches_q;
  assign perf_waits_o   = perf_waits_q;
`else
  logic unused_latch;
  assign unused_latch = latch;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        next_pc = 1'b0, jmp = 1'b0, branch = 1'b0, zero = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] garble = 32'd0;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid, fetch_err;
  logic [31:0] pc;

  logic        rst_hi = 1'b1;
  logic        nxt_hi = 1'b0, jmp_hi = 1'b0, br_hi = 1'b0, zero_hi = 1'b0;
  logic [31:0] instr_hi, pc_hi;
  logic [5:0]  op_hi;
  logic        valid_hi, err_hi;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h20) return 32'h1022_FFFE;
    return {6'h28, a[25:0]};
  endfunction

  pc_fetch_unit_if bus ();
  pc_fetch_unit_if bus_hi ();
  assign bus.ready    = ready;
  assign bus.rdata    = mem_word(bus.addr) ^ garble;
  assign bus_hi.ready = 1'b1;
  assign bus_hi.rdata = 32'h0800_0100;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetches, perf_waits, pf_hi, pw_hi;
`endif

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(MAXW)) u_dut (
    .clk_i(clk), .rst_i(rst), .next_pc_i(next_pc), .jmp_i(jmp), .branch_i(branch),
    .zero_i(zero), .imem(bus), .instr_o(instr), .op_o(op), .instr_valid_o(instr_valid),
    .pc_o(pc), .fetch_err_o(fetch_err)
`ifdef FETCH_PERF_EN
    , .perf_fetches_o(perf_fetches), .perf_waits_o(perf_waits)
`endif
  );

  pc_fetch_unit #(.RESET_PC(32'h4000_0000), .MAX_WAIT(MAXW)) u_dut_hi (
    .clk_i(clk), .rst_i(rst_hi), .next_pc_i(nxt_hi), .jmp_i(jmp_hi), .branch_i(br_hi),
    .zero_i(zero_hi), .imem(bus_hi), .instr_o(instr_hi), .op_o(op_hi), .instr_valid_o(valid_hi),
    .pc_o(pc_hi), .fetch_err_o(err_hi)
`ifdef FETCH_PERF_EN
    , .perf_fetches_o(pf_hi), .perf_waits_o(pw_hi)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference model: boot cycle, fetch in progress, or instruction held.
  bit          m_boot = 1'b1;
  bit          m_fetching = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_err = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_fetches = 32'd0;
  logic [31:0] m_waits = 32'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_boot <= 1'b1; m_fetching <= 1'b0; m_valid <= 1'b0; m_err <= 1'b0;
      m_wait <= 0; m_pc <= 32'd0; m_instr <= 32'd0; m_fetches <= 32'd0; m_waits <= 32'd0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
      m_fetching <= 1'b1;
      m_wait <= 0;
    end else if (m_fetching) begin
      if (m_wait > 0) m_waits <= m_waits + 32'd1;
      if (ready) begin
        m_instr <= mem_word(m_pc) ^ garble;
        m_fetching <= 1'b0;
        m_valid <= 1'b1;
        m_fetches <= m_fetches + 32'd1;
      end else begin
        m_wait <= (m_wait >= 255) ? 255 : m_wait + 1;
        if (m_wait + 1 >= MAXW) m_err <= 1'b1;
      end
    end else if (m_valid && next_pc) begin
      m_valid <= 1'b0;
      m_fetching <= 1'b1;
      m_wait <= 0;
      if (jmp)
        m_pc <= {m_pc[31:28] + ((m_pc[27:0] >= 28'hFFF_FFFC) ? 4'd1 : 4'd0), m_instr[25:0], 2'b00};
      else if (branch && zero)
        m_pc <= m_pc + 32'd4 + 32'(int'(signed'(m_instr[15:0])) * 4);
      else
        m_pc <= m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("req", 32'(bus.req), 32'(m_fetching));
      if (m_fetching) check("addr", bus.addr, m_pc);
      check("pc", pc, m_pc);
      check("valid", 32'(instr_valid), 32'(m_valid));
      check("instr", instr, m_instr);
      check("op", 32'(op), 32'(m_instr[31:26]));
      check("fetch_err", 32'(fetch_err), 32'(m_err));
`ifdef FETCH_PERF_EN
      check("perf_fetches", perf_fetches, m_fetches);
      check("perf_waits", perf_waits, m_waits);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic j, input logic b, input logic z);
    next_pc = 1'b1; jmp = j; branch = b; zero = z;
    tick();
    next_pc = 1'b0; jmp = 1'b0; branch = 1'b0; zero = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!instr_valid && n < budget) begin tick(); n++; end
    check("wait_valid", 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_valid_hi(input int budget);
    int n = 0;
    while (!valid_hi && n < budget) begin tick(); n++; end
    check("hi_wait_valid", 32'(valid_hi), 32'd1);
  endtask

  initial begin
    tick(); tick();
    started = 1'b1;
    check("rst_pc", pc, 32'd0);
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_op", 32'(op), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    rst = 1'b0;
    tick();
    check("c2_req", 32'(bus.req), 32'd1);
    check("c2_addr", bus.addr, 32'd0);
    tick();
    check("c3_valid", 32'(instr_valid), 32'd1);
    check("c3_instr", instr, 32'hA000_0000);

    garble = 32'hDEAD_BEEF;
    next_pc = 1'b0;
    tick(); tick();
    check("hold_frozen", instr, 32'hA000_0000);
    garble = 32'd0;

    for (int i = 0; i < 4; i++) begin pulse(0, 0, 0); wait_valid(4); end
    check("seq_pc10", pc, 32'h10);
    pulse(0, 0, 0);
    check("seq_pc14", pc, 32'h14);
    check("seq_addr14", bus.addr, 32'h14);
    wait_valid(4);

    for (int i = 0; i < 3; i++) begin pulse(0, 0, 0); wait_valid(4); end
    check("beq_instr", instr, 32'h1022_FFFE);
    pulse(0, 1, 1);
    check("beq_taken", pc, 32'h1C);
    wait_valid(4);
    pulse(0, 0, 0); wait_valid(4);
    pulse(0, 1, 0);
    check("beq_not_taken", pc, 32'h24);
    wait_valid(4);

    ready = 1'b0;
    pulse(0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      next_pc = (k == 5); jmp = (k == 5);
      tick();
      if (k == MAXW - 1) check("err_before", 32'(fetch_err), 32'd0);
      if (k == MAXW) check("err_at_max", 32'(fetch_err), 32'd1);
    end
    next_pc = 1'b0; jmp = 1'b0;
    check("wait_addr", bus.addr, 32'h28);
    check("wait_pc", pc, 32'h28);
    ready = 1'b1;
    wait_valid(3);
    check("late_instr", instr, 32'hA000_0028);
    check("err_sticky", 32'(fetch_err), 32'd1);

    ready = 1'b0;
    pulse(0, 0, 0);
    tick(); tick(); tick();
    #3 rst = 1'b1;
    #1;
    check("rst_async_req", 32'(bus.req), 32'd0);
    check("rst_async_pc", pc, 32'd0);
`ifdef FETCH_PERF_EN
    check("rst_perf_f", perf_fetches, 32'd0);
    check("rst_perf_w", perf_waits, 32'd0);
`endif
    ready = 1'b1;
    tick(); tick();
    check("rst_no_latch", instr, 32'd0);
    rst = 1'b0;
    wait_valid(4);
    check("reboot_pc", pc, 32'd0);

    rst_hi = 1'b0;
    wait_valid_hi(4);
    check("hi_pc", pc_hi, 32'h4000_0000);
    check("hi_op", 32'(op_hi), 32'd2);
`ifdef FETCH_PERF_EN
    check("hi_perf_f", pf_hi, 32'd1);
    check("hi_perf_w", pw_hi, 32'd0);
`endif
    nxt_hi = 1'b1; jmp_hi = 1'b1;
    tick();
    nxt_hi = 1'b0; jmp_hi = 1'b0;
    check("hi_jmp_pc", pc_hi, 32'h4000_0400);
    check("hi_jmp_req", 32'(bus_hi.req), 32'd1);
    wait_valid_hi(4);
    nxt_hi = 1'b1; jmp_hi = 1'b1; br_hi = 1'b1; zero_hi = 1'b1;
    tick();
    nxt_hi = 1'b0; jmp_hi = 1'b0; br_hi = 1'b0; zero_hi = 1'b0;
    check("hi_jmp_prio", pc_hi, 32'h4000_0400);
    check("hi_err", 32'(err_hi), 32'd0);
    check("hi_instr", instr_hi, 32'h0800_0100);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
